object_table_reader: RTL and testbench
======================================

Name: object_table_reader

Overview:
- End-of-frame consumer of the tables built by the labeler during a frame.
- After the frame, it flattens the merge table (label -> root label) and folds each non-root label's moments (area, sum x*p, sum y*p) into its root's data-table entry.
- It then streams one record per surviving object over a valid/ready interface to the centroid/bounding stage.
- It owns the merge-table and data-table ports only while busy; the labeler owns them otherwise (arbitration is outside this block).

Parameters:
- LABEL_W, 8, label/address width (matches `WORD_SIZE).
- ACC_W, 128, width of each moment field; a data-table word is 3*ACC_W, laid out {sum_y, sum_x, area}.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse at end of frame; ignored while busy.
- num_labels  in  LABEL_W  labeler's next-free label; valid labels are 1..num_labels-1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last record has been accepted.
- mt_r_addr  out  LABEL_W  merge-table read address.
- mt_r_data  in  LABEL_W  merge-table read data, one cycle after the address.
- mt_wen  out  1  merge-table write enable.
- mt_w_addr  out  LABEL_W  merge-table write address.
- mt_w_data  out  LABEL_W  merge-table write data.
- dt_r_addr  out  LABEL_W  data-table read address.
- dt_r_data  in  3*ACC_W  data-table read data, one cycle after the address.
- dt_wen  out  1  data-table write enable.
- dt_w_addr  out  LABEL_W  data-table write address.
- dt_w_data  out  3*ACC_W  data-table write data.
- obj_valid  out  1  output record valid.
- obj_ready  in  1  downstream accepts the record.
- obj_label  out  LABEL_W  root label of the object.
- obj_area  out  ACC_W  sum of p.
- obj_sum_x  out  ACC_W  sum of x*p.
- obj_sum_y  out  ACC_W  sum of y*p.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - busy, done, mt_wen, dt_wen and obj_valid go to 0.
  - All address, data and obj_* registers go to 0.
  - A reset mid-operation abandons the pass; table contents are left as they are.
- Invariant relied on: every merge entry satisfies merge[L] <= L, because the labeler writes max -> min and new labels write self.
- IDLE:
  - On start, latch N = num_labels and set L = 1.
  - If N <= 1, pulse done with no table access.
  - Otherwise go to FLATTEN.
- FLATTEN, for L = 1..N-1 ascending:
  - Read merge[L] -> t.
  - If t == L, do nothing more.
  - Else read merge[t] -> r. Entry t is already flat because t < L. Write merge[L] = r.
  - Cost per label: 2 cycles if t == L, 4 cycles otherwise.
  - After L = N-1, set L = 1 and go to FOLD.
- FOLD, for L = 1..N-1 ascending:
  - Read merge[L] -> r.
  - If r != L:
    - Read data[L], then read data[r].
    - Write data[r] = fieldwise sum, each field wrapping mod 2^ACC_W.
    - Write data[L] = 0.
  - Reads of data[r] always see the latest write; there are no read-during-write hazards because the write completes before the next read is issued.
  - After L = N-1, set L = 1 and go to EMIT.
- EMIT, for L = 1..N-1 ascending:
  - Read merge[L] and data[L] in parallel.
  - If merge[L] == L and area != 0, present the record with obj_valid = 1.
  - Hold the record stable until obj_valid && obj_ready, then advance.
  - Otherwise skip the label without asserting obj_valid.
  - After the last label, pulse done and return to IDLE.
- Handshake: obj_valid never drops without acceptance, and obj_* never change while obj_valid && !obj_ready.
- At most one write per table per cycle. mt_wen is never asserted outside FLATTEN; dt_wen is never asserted outside FOLD.
- Labels 0 and >= N are never read or written.
- A label whose area is 0 (merged away, or background) never produces a record.

Decomposition:
- Shared package global.vh: add OBJ_WIDTH (128), NUM_OBJS (3) and field offsets AREA_LSB = 0, SX_LSB = ACC_W, SY_LSB = 2*ACC_W, so the labeler and this block share one data-table layout.
- State encodings stay local to the block.
- One sub-module: moment_adder, a combinational 3-field add of two 3*ACC_W words with independent wrap per field.

Test Plan:
- N = 1, start -> done one cycle after busy rises, no table access, obj_valid never asserted.
- Merge = {1:1, 2:2, 3:3}, data area = {5, 7, 9} -> three records: labels 1, 2, 3 with areas 5, 7, 9; done after the third acceptance.
- Chain merge = {1:1, 2:1, 3:2}, areas {4, 3, 2}, sum_x {10, 20, 30} -> after FLATTEN, merge[3] = 1; single record label 1, area 9, sum_x 60; data[2] and data[3] are 0.
- Backpressure: obj_ready = 0 for 5 cycles on the first record -> obj_* stable, obj_valid held, no second record, correct order afterwards.
- Reset asserted during FOLD -> busy, obj_valid, dt_wen and mt_wen go to 0 asynchronously; a new start then runs a full pass from IDLE.
- Wrap: areas 2^ACC_W - 1 and 2 merged into label 1 -> obj_area = 1; start pulsed while busy -> ignored, no restart.

Source files
------------

// File: rtl/object_table_reader_pkg.sv
// Shared constants and types for the end-of-frame object table reader.
// Holds the data-table word layout {sum_y, sum_x, area} used by both the labeler and the reader.
// No logic lives here; only widths, field offsets and packed record types.
package object_table_reader_pkg;

  localparam int LABEL_W   = 8;
  localparam int OBJ_WIDTH = 128;
  localparam int NUM_OBJS  = 3;
  localparam int ACC_W     = OBJ_WIDTH;

  // Field offsets inside one data-table word.
  localparam int AREA_LSB  = 0;
  localparam int SX_LSB    = ACC_W;
  localparam int SY_LSB    = 2 * ACC_W;
  localparam int DT_W      = NUM_OBJS * ACC_W;

  typedef logic [LABEL_W-1:0] label_t;
  typedef logic [ACC_W-1:0]   acc_t;

  // First member lands in the MSBs, so area sits at bit 0 as in the table layout.
  typedef struct packed {
    acc_t sum_y;
    acc_t sum_x;
    acc_t area;
  } moments_t;

endpackage

// File: rtl/object_table_reader_if.sv
// Bundle of the reader's control, table-port and object-stream signals.
// master: the reader itself (drives table addresses/writes and the record stream).
// slave: the surrounding frame logic, the tables and the downstream consumer.
interface object_table_reader_if;
  import object_table_reader_pkg::*;

  logic            start;
  label_t          num_labels;
  logic            busy;
  logic            done;

  label_t          mt_r_addr;
  label_t          mt_r_data;
  logic            mt_wen;
  label_t          mt_w_addr;
  label_t          mt_w_data;

  label_t          dt_r_addr;
  logic [DT_W-1:0] dt_r_data;
  logic            dt_wen;
  label_t          dt_w_addr;
  logic [DT_W-1:0] dt_w_data;

  logic            obj_valid;
  logic            obj_ready;
  label_t          obj_label;
  acc_t            obj_area;
  acc_t            obj_sum_x;
  acc_t            obj_sum_y;

  modport master (
    input  start, num_labels, mt_r_data, dt_r_data, obj_ready,
    output busy, done,
    output mt_r_addr, mt_wen, mt_w_addr, mt_w_data,
    output dt_r_addr, dt_wen, dt_w_addr, dt_w_data,
    output obj_valid, obj_label, obj_area, obj_sum_x, obj_sum_y
  );

  modport slave (
    output start, num_labels, mt_r_data, dt_r_data, obj_ready,
    input  busy, done,
    input  mt_r_addr, mt_wen, mt_w_addr, mt_w_data,
    input  dt_r_addr, dt_wen, dt_w_addr, dt_w_data,
    input  obj_valid, obj_label, obj_area, obj_sum_x, obj_sum_y
  );

endinterface

// File: rtl/object_table_reader_moment_adder.sv
// Adds two data-table words field by field (area, sum_x, sum_y).
// Purely combinational; each field wraps independently so no carry crosses fields.
// No handshake; the caller samples the result in the cycle it needs it.
module object_table_reader_moment_adder
  import object_table_reader_pkg::*;
(
  input  logic [DT_W-1:0] a_i,
  input  logic [DT_W-1:0] b_i,
  output logic [DT_W-1:0] sum_o
);

  assign sum_o[AREA_LSB +: ACC_W] = a_i[AREA_LSB +: ACC_W] + b_i[AREA_LSB +: ACC_W];
  assign sum_o[SX_LSB   +: ACC_W] = a_i[SX_LSB   +: ACC_W] + b_i[SX_LSB   +: ACC_W];
  assign sum_o[SY_LSB   +: ACC_W] = a_i[SY_LSB   +: ACC_W] + b_i[SY_LSB   +: ACC_W];

endmodule

// File: rtl/object_table_reader.sv
// End-of-frame pass: flatten merge table, fold child moments into roots, stream one record per object.
// Latency: 2 cycles per root label / 4 per child in flatten, 2 or 6 in fold, 2 per label plus handshake in emit.
// Backpressure: a presented record is held stable until obj_ready; nothing else advances meanwhile.
module object_table_reader
  import object_table_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  object_table_reader_if.master bus
);

  // *_A states present an address, the following state consumes the read data.
  typedef enum logic [4:0] {
    S_IDLE,
    S_EMPTY,
    FL_A,
    FL_T,
    FL_RA,
    FL_R,
    FL_END,
    FO_A,
    FO_R,
    FO_LA,
    FO_L,
    FO_S,
    FO_W1,
    FO_END,
    EM_A,
    EM_D,
    EM_HOLD
  } state_t;

  state_t          state_q;
  label_t          n_q;
  label_t          l_q;
  label_t          r_q;
  logic [DT_W-1:0] dl_q;
  logic            busy_q;
  logic            done_q;

  label_t          mt_r_addr_q;
  logic            mt_wen_q;
  label_t          mt_w_addr_q;
  label_t          mt_w_data_q;

  label_t          dt_r_addr_q;
  logic            dt_wen_q;
  label_t          dt_w_addr_q;
  logic [DT_W-1:0] dt_w_data_q;

  logic            obj_valid_q;
  label_t          obj_label_q;
  moments_t        obj_mom_q;

  moments_t        rd_mom;
  logic [DT_W-1:0] sum_d;
  label_t          l_d;
  logic            last_lbl;

  assign rd_mom   = moments_t'(bus.dt_r_data);
  assign l_d      = l_q + label_t'(1);
  assign last_lbl = (l_q == n_q - label_t'(1));

  // data[L] (held in dl_q) plus data[r] arriving on the read port.
  object_table_reader_moment_adder u_moment_adder (
    .a_i   (dl_q),
    .b_i   (bus.dt_r_data),
    .sum_o (sum_d)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mt_r_addr = mt_r_addr_q;
  assign bus.mt_wen    = mt_wen_q;
  assign bus.mt_w_addr = mt_w_addr_q;
  assign bus.mt_w_data = mt_w_data_q;
  assign bus.dt_r_addr = dt_r_addr_q;
  assign bus.dt_wen    = dt_wen_q;
  assign bus.dt_w_addr = dt_w_addr_q;
  assign bus.dt_w_data = dt_w_data_q;
  assign bus.obj_valid = obj_valid_q;
  assign bus.obj_label = obj_label_q;
  assign bus.obj_area  = obj_mom_q.area;
  assign bus.obj_sum_x = obj_mom_q.sum_x;
  assign bus.obj_sum_y = obj_mom_q.sum_y;

  // Whole pass sequencer; write enables and done are single-cycle pulses cleared by default.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      l_q         <= '0;
      r_q         <= '0;
      dl_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mt_r_addr_q <= '0;
      mt_wen_q    <= 1'b0;
      mt_w_addr_q <= '0;
      mt_w_data_q <= '0;
      dt_r_addr_q <= '0;
      dt_wen_q    <= 1'b0;
      dt_w_addr_q <= '0;
      dt_w_data_q <= '0;
      obj_valid_q <= 1'b0;
      obj_label_q <= '0;
      obj_mom_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      mt_wen_q <= 1'b0;
      dt_wen_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            n_q    <= bus.num_labels;
            l_q    <= label_t'(1);
            busy_q <= 1'b1;
            if (bus.num_labels <= label_t'(1)) begin
              state_q <= S_EMPTY;
            end else begin
              mt_r_addr_q <= label_t'(1);
              state_q     <= FL_A;
            end
          end
        end

        // No valid labels: close the pass without touching either table.
        S_EMPTY: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        FL_A: state_q <= FL_T;

        // t = merge[L]; roots are already flat, children need their parent's root.
        FL_T: begin
          if (bus.mt_r_data == l_q) begin
            if (last_lbl) begin
              l_q         <= label_t'(1);
              mt_r_addr_q <= label_t'(1);
              state_q     <= FO_A;
            end else begin
              l_q         <= l_d;
              mt_r_addr_q <= l_d;
              state_q     <= FL_A;
            end
          end else begin
            mt_r_addr_q <= bus.mt_r_data;
            state_q     <= FL_RA;
          end
        end

        FL_RA: state_q <= FL_R;

        // r = merge[t], already flat because t < L; point L straight at it.
        FL_R: begin
          mt_wen_q    <= 1'b1;
          mt_w_addr_q <= l_q;
          mt_w_data_q <= bus.mt_r_data;
          if (last_lbl) begin
            state_q <= FL_END;
          end else begin
            l_q         <= l_d;
            mt_r_addr_q <= l_d;
            state_q     <= FL_A;
          end
        end

        // Lets the final merge write land before fold starts.
        FL_END: begin
          l_q         <= label_t'(1);
          mt_r_addr_q <= label_t'(1);
          state_q     <= FO_A;
        end

        FO_A: state_q <= FO_R;

        FO_R: begin
          if (bus.mt_r_data == l_q) begin
            if (last_lbl) begin
              l_q         <= label_t'(1);
              mt_r_addr_q <= label_t'(1);
              dt_r_addr_q <= label_t'(1);
              state_q     <= EM_A;
            end else begin
              l_q         <= l_d;
              mt_r_addr_q <= l_d;
              state_q     <= FO_A;
            end
          end else begin
            r_q         <= bus.mt_r_data;
            dt_r_addr_q <= l_q;
            state_q     <= FO_LA;
          end
        end

        FO_LA: begin
          dt_r_addr_q <= r_q;
          state_q     <= FO_L;
        end

        FO_L: begin
          dl_q    <= bus.dt_r_data;
          state_q <= FO_S;
        end

        // data[r] is on the read port now; the root absorbs the child.
        FO_S: begin
          dt_wen_q    <= 1'b1;
          dt_w_addr_q <= r_q;
          dt_w_data_q <= sum_d;
          state_q     <= FO_W1;
        end

        // Clear the child so it can never be emitted.
        FO_W1: begin
          dt_wen_q    <= 1'b1;
          dt_w_addr_q <= l_q;
          dt_w_data_q <= '0;
          if (last_lbl) begin
            state_q <= FO_END;
          end else begin
            l_q         <= l_d;
            mt_r_addr_q <= l_d;
            state_q     <= FO_A;
          end
        end

        FO_END: begin
          l_q         <= label_t'(1);
          mt_r_addr_q <= label_t'(1);
          dt_r_addr_q <= label_t'(1);
          state_q     <= EM_A;
        end

        EM_A: state_q <= EM_D;

        EM_D: begin
          if ((bus.mt_r_data == l_q) && (rd_mom.area != '0)) begin
            obj_valid_q <= 1'b1;
            obj_label_q <= l_q;
            obj_mom_q   <= rd_mom;
            state_q     <= EM_HOLD;
          end else if (last_lbl) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            l_q         <= l_d;
            mt_r_addr_q <= l_d;
            dt_r_addr_q <= l_d;
            state_q     <= EM_A;
          end
        end

        EM_HOLD: begin
          if (bus.obj_ready) begin
            obj_valid_q <= 1'b0;
            if (last_lbl) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              l_q         <= l_d;
              mt_r_addr_q <= l_d;
              dt_r_addr_q <= l_d;
              state_q     <= EM_A;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_object_table_reader.sv
// Bench for object_table_reader: behavioural merge/data tables, directed frames, scoreboard on the record stream.
// Expected records are queued at stimulus time and popped by a negedge monitor on each accepted record.
// The monitor also checks record stability under backpressure and the legality of every table write.
module tb_object_table_reader;
  import object_table_reader_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  object_table_reader_if bus();

  object_table_reader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous-read table models: data appears the cycle after the address.
  label_t          mt_mem [0:255];
  logic [DT_W-1:0] dt_mem [0:255];
  logic            ld_en;
  label_t          ld_addr;
  label_t          ld_mt;
  logic [DT_W-1:0] ld_dt;

  always @(posedge clk) begin
    if (ld_en) begin
      mt_mem[ld_addr] <= ld_mt;
      dt_mem[ld_addr] <= ld_dt;
    end
    if (bus.mt_wen) mt_mem[bus.mt_w_addr] <= bus.mt_w_data;
    if (bus.dt_wen) dt_mem[bus.dt_w_addr] <= bus.dt_w_data;
    bus.mt_r_data <= mt_mem[bus.mt_r_addr];
    bus.dt_r_data <= dt_mem[bus.dt_r_addr];
  end

  typedef struct packed {
    label_t lbl;
    acc_t   area;
    acc_t   sx;
    acc_t   sy;
  } rec_t;

  rec_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     done_cnt = 0;
  label_t cur_n = '0;
  logic   hold_v = 1'b0;
  rec_t   hold_r;

  function automatic void chk(string name, logic [399:0] act, logic [399:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic rec_t mk_rec(label_t l, acc_t a, acc_t sx, acc_t sy);
    rec_t r;
    r.lbl  = l;
    r.area = a;
    r.sx   = sx;
    r.sy   = sy;
    return r;
  endfunction

  // Monitor: scoreboard pops, hold-stability, done counting, write legality.
  always @(negedge clk) begin
    rec_t cur;
    rec_t e;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      cur = mk_rec(bus.obj_label, bus.obj_area, bus.obj_sum_x, bus.obj_sum_y);
      if (hold_v) begin
        chk("held_valid", 400'(bus.obj_valid), 400'(1));
        if (bus.obj_valid) chk("held_record", 400'(cur), 400'(hold_r));
      end
      if (bus.obj_valid && bus.obj_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got label %0d area %0h, expected no record", cur.lbl, cur.area);
        end else begin
          e = exp_q.pop_front();
          chk("rec_label", 400'(cur.lbl), 400'(e.lbl));
          chk("rec_area",  400'(cur.area), 400'(e.area));
          chk("rec_sum_x", 400'(cur.sx), 400'(e.sx));
          chk("rec_sum_y", 400'(cur.sy), 400'(e.sy));
        end
        hold_v = 1'b0;
      end else if (bus.obj_valid) begin
        hold_v = 1'b1;
        hold_r = cur;
      end else begin
        hold_v = 1'b0;
      end
      if (bus.done) done_cnt++;
      if (bus.mt_wen) begin
        chk("mt_wen_while_busy", 400'(bus.busy), 400'(1));
        chk("mt_waddr_in_range", 400'(bus.mt_w_addr >= 1 && bus.mt_w_addr < cur_n), 400'(1));
      end
      if (bus.dt_wen) begin
        chk("dt_wen_while_busy", 400'(bus.busy), 400'(1));
        chk("dt_waddr_in_range", 400'(bus.dt_w_addr >= 1 && bus.dt_w_addr < cur_n), 400'(1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(label_t a, label_t m, acc_t ar, acc_t sx, acc_t sy);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_mt   = m;
    ld_dt   = {sy, sx, ar};
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic go(label_t n);
    cur_n          = n;
    bus.num_labels = n;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(int exp, string name);
    for (int i = 0; i < 3000 && done_cnt < exp; i++) @(negedge clk);
    #1;
    chk(name, 400'(done_cnt), 400'(exp));
    chk({name, "_queue_drained"}, 400'(exp_q.size()), 400'(0));
  endtask

  // Identity tables with a live-looking label 4 that must stay unread when N = 4.
  task automatic load_identity();
    load(8'd0, 8'd0, 128'd0, 128'd0, 128'd0);
    load(8'd1, 8'd1, 128'd5, 128'd50, 128'd500);
    load(8'd2, 8'd2, 128'd7, 128'd70, 128'd700);
    load(8'd3, 8'd3, 128'd9, 128'd90, 128'd900);
    load(8'd4, 8'd4, 128'd99, 128'd1, 128'd1);
  endtask

  task automatic load_chain();
    load(8'd0, 8'd0, 128'd0, 128'd0, 128'd0);
    load(8'd1, 8'd1, 128'd4, 128'd10, 128'd1);
    load(8'd2, 8'd1, 128'd3, 128'd20, 128'd2);
    load(8'd3, 8'd2, 128'd2, 128'd30, 128'd3);
    load(8'd4, 8'd4, 128'd99, 128'd1, 128'd1);
  endtask

  initial begin
    acc_t all_ones;
    all_ones       = '1;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.num_labels = '0;
    bus.obj_ready  = 1'b1;
    ld_en          = 1'b0;
    ld_addr        = '0;
    ld_mt          = '0;
    ld_dt          = '0;
    repeat (3) tick();

    chk("rst_busy",      400'(bus.busy), 400'(0));
    chk("rst_done",      400'(bus.done), 400'(0));
    chk("rst_obj_valid", 400'(bus.obj_valid), 400'(0));
    chk("rst_mt_wen",    400'(bus.mt_wen), 400'(0));
    chk("rst_dt_wen",    400'(bus.dt_wen), 400'(0));
    chk("rst_mt_r_addr", 400'(bus.mt_r_addr), 400'(0));
    chk("rst_dt_r_addr", 400'(bus.dt_r_addr), 400'(0));
    chk("rst_obj_area",  400'(bus.obj_area), 400'(0));
    reset_n = 1'b1;
    tick();

    // N = 1: busy for one cycle, then done, no access and no record.
    go(8'd1);
    chk("n1_busy_rises", 400'(bus.busy), 400'(1));
    chk("n1_done_low",   400'(bus.done), 400'(0));
    tick();
    chk("n1_busy_falls", 400'(bus.busy), 400'(0));
    chk("n1_done_pulse", 400'(bus.done), 400'(1));
    wait_done(1, "n1_done");

    // Three independent roots.
    load_identity();
    exp_q.push_back(mk_rec(8'd1, 128'd5, 128'd50, 128'd500));
    exp_q.push_back(mk_rec(8'd2, 128'd7, 128'd70, 128'd700));
    exp_q.push_back(mk_rec(8'd3, 128'd9, 128'd90, 128'd900));
    go(8'd4);
    wait_done(2, "ident_done");

    // Chain 3 -> 2 -> 1 collapses into label 1.
    load_chain();
    exp_q.push_back(mk_rec(8'd1, 128'd9, 128'd60, 128'd6));
    go(8'd4);
    wait_done(3, "chain_done");
    chk("chain_merge2", 400'(mt_mem[2]), 400'(1));
    chk("chain_merge3", 400'(mt_mem[3]), 400'(1));
    chk("chain_merge4_untouched", 400'(mt_mem[4]), 400'(4));
    chk("chain_data1", 400'(dt_mem[1]), 400'({128'd6, 128'd60, 128'd9}));
    chk("chain_data2", 400'(dt_mem[2]), 400'(0));
    chk("chain_data3", 400'(dt_mem[3]), 400'(0));

    // Backpressure on the first record for five cycles.
    load_identity();
    exp_q.push_back(mk_rec(8'd1, 128'd5, 128'd50, 128'd500));
    exp_q.push_back(mk_rec(8'd2, 128'd7, 128'd70, 128'd700));
    exp_q.push_back(mk_rec(8'd3, 128'd9, 128'd90, 128'd900));
    bus.obj_ready = 1'b0;
    go(8'd4);
    for (int i = 0; i < 200 && !bus.obj_valid; i++) tick();
    chk("bp_valid_seen", 400'(bus.obj_valid), 400'(1));
    repeat (5) tick();
    chk("bp_valid_held", 400'(bus.obj_valid), 400'(1));
    chk("bp_label_held", 400'(bus.obj_label), 400'(1));
    bus.obj_ready = 1'b1;
    wait_done(4, "bp_done");

    // Asynchronous reset in the middle of the fold pass.
    load_chain();
    go(8'd4);
    for (int i = 0; i < 200 && bus.dt_r_addr != 8'd2; i++) tick();
    chk("fold_reached", 400'(bus.dt_r_addr), 400'(2));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy",      400'(bus.busy), 400'(0));
    chk("arst_obj_valid", 400'(bus.obj_valid), 400'(0));
    chk("arst_dt_wen",    400'(bus.dt_wen), 400'(0));
    chk("arst_mt_wen",    400'(bus.mt_wen), 400'(0));
    tick();
    reset_n = 1'b1;
    tick();
    load_chain();
    exp_q.push_back(mk_rec(8'd1, 128'd9, 128'd60, 128'd6));
    go(8'd4);
    wait_done(5, "after_rst_done");

    // Area wrap, and a start pulsed mid-pass must be ignored.
    load(8'd0, 8'd0, 128'd0, 128'd0, 128'd0);
    load(8'd1, 8'd1, all_ones, 128'd1, 128'd0);
    load(8'd2, 8'd1, 128'd2, 128'd5, 128'd7);
    load(8'd3, 8'd3, 128'd99, 128'd1, 128'd1);
    exp_q.push_back(mk_rec(8'd1, 128'd1, 128'd6, 128'd7));
    go(8'd3);
    tick();
    bus.num_labels = 8'd1;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    chk("start_ignored_busy", 400'(bus.busy), 400'(1));
    wait_done(6, "wrap_done");
    repeat (20) tick();
    chk("no_restart_done_cnt", 400'(done_cnt), 400'(6));
    chk("no_restart_idle", 400'(bus.busy), 400'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
